// File: rtl/vpu_result_wb_pkg.sv
// Shared configuration and entry format for the VPU result writeback stage.
package vpu_result_wb_pkg;

    localparam int unsigned OUT_WIDTH      = 16;
    localparam int unsigned ROW_A          = 4;
    localparam int unsigned ADDR_WIDTH     = 16;
    localparam int unsigned K_TILES_DEF    = 2;
    localparam int unsigned FIFO_DEPTH_DEF = 4;
    localparam int unsigned ROW_WIDTH      = OUT_WIDTH * ROW_A;

    // Signed saturation bounds of one result lane.
    localparam logic [OUT_WIDTH-1:0] SAT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0] SAT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    typedef struct packed {
        logic                  last;
        logic [ADDR_WIDTH-1:0] addr;
        logic [ROW_WIDTH-1:0]  data;
    } wb_entry_t;

    localparam int unsigned ENTRY_WIDTH = $bits(wb_entry_t);

endpackage

// File: rtl/vpu_wb_fifo.sv
// Synchronous FIFO for writeback entries; a push into a full FIFO succeeds
// when a pop happens in the same cycle.
module vpu_wb_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CW'(DEPTH));
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_data    = r_mem[r_rd_ptr];

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/vpu_result_wb.sv
// Result writeback: accumulates K_TILES partial tiles per row with signed
// saturation, queues reduced rows and drains them over a valid/ready port.
module vpu_result_wb
    import vpu_result_wb_pkg::*;
#(
    parameter int unsigned K_TILES    = K_TILES_DEF,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_deload_out,
    input  logic [ROW_WIDTH-1:0]  i_out,
    input  logic [ADDR_WIDTH-1:0] i_addr_res,
    input  logic                  i_tile_start,
    output logic                  o_mem_wr_valid,
    input  logic                  i_mem_wr_ready,
    output logic [ADDR_WIDTH-1:0] o_mem_wr_addr,
    output logic [ROW_WIDTH-1:0]  o_mem_wr_data,
    output logic                  o_tile_done,
    output logic                  o_overflow,
    output logic                  o_busy
);

    localparam int unsigned RW = (ROW_A > 1) ? $clog2(ROW_A) : 1;
    localparam int unsigned KW = (K_TILES > 1) ? $clog2(K_TILES) : 1;
    localparam logic [RW-1:0] ROW_LAST = RW'(ROW_A - 1);
    localparam logic [KW-1:0] K_LAST   = KW'(K_TILES - 1);

    logic [RW-1:0]         r_row_cnt;
    logic [KW-1:0]         r_k_cnt;
    logic [ROW_WIDTH-1:0]  r_acc [ROW_A];
    logic [ADDR_WIDTH-1:0] r_hold_addr;
    logic [ROW_WIDTH-1:0]  r_hold_data;
    logic                  r_overflow;
    logic                  r_tile_done;

    logic [RW-1:0]         w_row;
    logic [KW-1:0]         w_k;
    logic [ROW_WIDTH-1:0]  w_sum;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_empty;
    wb_entry_t             w_push_entry;
    wb_entry_t             w_head;

    // A coincident tile_start makes this row the first row of a fresh tile.
    assign w_row = i_tile_start ? '0 : r_row_cnt;
    assign w_k   = i_tile_start ? '0 : r_k_cnt;

    for (genvar l = 0; l < ROW_A; l++) begin : g_lane
        logic [OUT_WIDTH-1:0] w_a;
        logic [OUT_WIDTH-1:0] w_b;
        logic [OUT_WIDTH:0]   w_wide;
        logic [OUT_WIDTH-1:0] w_lane;

        assign w_a    = r_acc[w_row][OUT_WIDTH*l +: OUT_WIDTH];
        assign w_b    = i_out[OUT_WIDTH*l +: OUT_WIDTH];
        assign w_wide = {w_a[OUT_WIDTH-1], w_a} + {w_b[OUT_WIDTH-1], w_b};
        // Top two bits disagree exactly when the signed sum left the lane range.
        assign w_lane = (w_k == '0) ? w_b :
                        (w_wide[OUT_WIDTH] != w_wide[OUT_WIDTH-1]) ?
                            (w_wide[OUT_WIDTH] ? SAT_MIN : SAT_MAX) :
                        w_wide[OUT_WIDTH-1:0];
        assign w_sum[OUT_WIDTH*l +: OUT_WIDTH] = w_lane;
    end

    assign w_push            = i_deload_out && (w_k == K_LAST);
    assign w_pop             = i_mem_wr_ready && !w_empty;
    assign w_push_entry.last = (w_row == ROW_LAST);
    assign w_push_entry.addr = i_addr_res;
    assign w_push_entry.data = w_sum;

    vpu_wb_fifo #(
        .WIDTH (ENTRY_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_push    (w_push),
        .i_pop     (w_pop),
        .i_data    (w_push_entry),
        .o_data    (w_head),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int r = 0; r < ROW_A; r++) begin
                r_acc[r] <= '0;
            end
            r_row_cnt <= '0;
            r_k_cnt   <= '0;
        end else begin
            if (i_tile_start) begin
                for (int r = 0; r < ROW_A; r++) begin
                    r_acc[r] <= '0;
                end
            end
            if (i_deload_out) begin
                r_acc[w_row] <= w_sum;
                if (w_row == ROW_LAST) begin
                    r_row_cnt <= '0;
                    r_k_cnt   <= (w_k == K_LAST) ? '0 : w_k + KW'(1);
                end else begin
                    r_row_cnt <= w_row + RW'(1);
                    r_k_cnt   <= w_k;
                end
            end else if (i_tile_start) begin
                r_row_cnt <= '0;
                r_k_cnt   <= '0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_overflow  <= 1'b0;
            r_tile_done <= 1'b0;
            r_hold_addr <= '0;
            r_hold_data <= '0;
        end else begin
            if (w_push && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
            r_tile_done <= w_pop && w_head.last;
            // Keep the last written word visible on the port once the FIFO empties.
            if (w_pop) begin
                r_hold_addr <= w_head.addr;
                r_hold_data <= w_head.data;
            end
        end
    end

    assign o_mem_wr_valid = !w_empty;
    assign o_mem_wr_addr  = w_empty ? r_hold_addr : w_head.addr;
    assign o_mem_wr_data  = w_empty ? r_hold_data : w_head.data;
    assign o_tile_done    = r_tile_done;
    assign o_overflow     = r_overflow;
    assign o_busy         = (r_row_cnt != '0) || (r_k_cnt != '0) || !w_empty;

endmodule

// File: tb/tb_vpu_result_wb.sv
// Self-checking bench for vpu_result_wb: directed cases plus random traffic
// against a queue-based reference model.
module tb_vpu_result_wb;
    import vpu_result_wb_pkg::*;

    localparam int K     = K_TILES_DEF;
    localparam int DEPTH = FIFO_DEPTH_DEF;
    localparam int SMAX  = (2 ** (OUT_WIDTH - 1)) - 1;
    localparam int SMIN  = -(2 ** (OUT_WIDTH - 1));

    logic                  clk = 1'b0;
    logic                  reset_n = 1'b0;
    logic                  deload = 1'b0;
    logic                  tile_start = 1'b0;
    logic                  ready = 1'b0;
    logic [ROW_WIDTH-1:0]  out_row = '0;
    logic [ADDR_WIDTH-1:0] addr_res = '0;
    logic                  valid;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [ROW_WIDTH-1:0]  wr_data;
    logic                  tile_done;
    logic                  overflow;
    logic                  busy;

    always #5 clk = ~clk;

    vpu_result_wb dut (
        .i_clk          (clk),
        .i_reset_n      (reset_n),
        .i_deload_out   (deload),
        .i_out          (out_row),
        .i_addr_res     (addr_res),
        .i_tile_start   (tile_start),
        .o_mem_wr_valid (valid),
        .i_mem_wr_ready (ready),
        .o_mem_wr_addr  (wr_addr),
        .o_mem_wr_data  (wr_data),
        .o_tile_done    (tile_done),
        .o_overflow     (overflow),
        .o_busy         (busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: accumulator as ints, FIFO as a queue.
    typedef struct {
        logic                  last;
        logic [ADDR_WIDTH-1:0] addr;
        logic [ROW_WIDTH-1:0]  data;
    } ent_t;

    ent_t                  mq[$];
    int                    mrow;
    int                    mk;
    int                    macc[ROW_A][ROW_A];
    bit                    mover;
    bit                    mdone;
    logic [ADDR_WIDTH-1:0] mhold_addr;
    logic [ROW_WIDTH-1:0]  mhold_data;

    // Writes the DUT actually performed, and tile_done pulses it produced.
    logic [ADDR_WIDTH-1:0] log_addr[$];
    logic [ROW_WIDTH-1:0]  log_data[$];
    int                    done_cnt;

    function automatic int lane_of(input logic [ROW_WIDTH-1:0] v, input int l);
        logic [OUT_WIDTH-1:0] x;
        x = v[OUT_WIDTH*l +: OUT_WIDTH];
        return int'($signed(x));
    endfunction

    function automatic logic [ROW_WIDTH-1:0] splat(input int v);
        logic [ROW_WIDTH-1:0] r;
        for (int l = 0; l < ROW_A; l++) r[OUT_WIDTH*l +: OUT_WIDTH] = OUT_WIDTH'(v);
        return r;
    endfunction

    task automatic model_reset();
        mq.delete();
        mrow = 0;
        mk = 0;
        for (int r = 0; r < ROW_A; r++) for (int l = 0; l < ROW_A; l++) macc[r][l] = 0;
        mover = 0;
        mdone = 0;
        mhold_addr = '0;
        mhold_data = '0;
    endtask

    task automatic model_check();
        bit v;
        v = (mq.size() > 0);
        chk("valid", valid, v);
        chk("addr", wr_addr, v ? mq[0].addr : mhold_addr);
        chk("data", wr_data, v ? mq[0].data : mhold_data);
        chk("tile_done", tile_done, mdone);
        chk("overflow", overflow, mover);
        chk("busy", busy, (mrow != 0) || (mk != 0) || v);
    endtask

    task automatic model_step();
        bit                   pop;
        bit                   done_n;
        int                   row;
        int                   k;
        int                   s;
        logic [ROW_WIDTH-1:0] sum;
        pop = (mq.size() > 0) && ready;
        done_n = pop && mq[0].last;
        row = tile_start ? 0 : mrow;
        k = tile_start ? 0 : mk;
        if (pop) begin
            mhold_addr = mq[0].addr;
            mhold_data = mq[0].data;
            void'(mq.pop_front());
        end
        if (tile_start) for (int r = 0; r < ROW_A; r++) for (int l = 0; l < ROW_A; l++) macc[r][l] = 0;
        if (deload) begin
            for (int l = 0; l < ROW_A; l++) begin
                s = lane_of(out_row, l);
                if (k != 0) begin
                    s = s + macc[row][l];
                    if (s > SMAX) s = SMAX;
                    if (s < SMIN) s = SMIN;
                end
                macc[row][l] = s;
                sum[OUT_WIDTH*l +: OUT_WIDTH] = OUT_WIDTH'(s);
            end
            if (k == K - 1) begin
                if (mq.size() < DEPTH) mq.push_back('{last: (row == ROW_A - 1), addr: addr_res, data: sum});
                else mover = 1;
            end
            row++;
            if (row == ROW_A) begin
                row = 0;
                k++;
                if (k == K) k = 0;
            end
        end
        mrow = row;
        mk = k;
        mdone = done_n;
    endtask

    // One clock: check outputs, drive inputs, advance model and DUT. Entered at negedge.
    task automatic cyc(input logic ts, input logic dl, input logic [ROW_WIDTH-1:0] d,
                       input logic [ADDR_WIDTH-1:0] a, input logic rdy);
        model_check();
        if (tile_done) done_cnt++;
        tile_start = ts;
        deload = dl;
        out_row = d;
        addr_res = a;
        ready = rdy;
        if (valid && rdy) begin
            log_addr.push_back(wr_addr);
            log_data.push_back(wr_data);
        end
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input int v, input int a, input logic rdy);
        cyc(1'b0, 1'b1, splat(v), ADDR_WIDTH'(a), rdy);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, '0, '0, rdy);
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
        done_cnt = 0;
    endtask

    initial begin
        logic [ROW_WIDTH-1:0] d;
        logic [ROW_WIDTH-1:0] q;
        logic [15:0]          w16;

        model_reset();
        clear_log();
        repeat (2) @(negedge clk);
        chk("rst_addr", wr_addr, 0);
        chk("rst_data", wr_data, 0);
        reset_n = 1'b1;

        // Case 1: 5 + 7 over two k-tiles.
        cyc(1'b1, 1'b0, '0, '0, 1'b1);
        for (int r = 0; r < ROW_A; r++) send(5, r, 1'b1);
        for (int r = 0; r < ROW_A; r++) send(7, r, 1'b1);
        idle(6, 1'b1);
        chk("c1_nwrites", log_addr.size(), 4);
        for (int i = 0; i < log_addr.size(); i++) begin
            chk("c1_addr", log_addr[i], i);
            chk("c1_data", log_data[i], splat(12));
        end
        chk("c1_done", done_cnt, 1);
        chk("c1_busy", busy, 0);

        // Case 2: saturation on lanes 0 and 1.
        clear_log();
        cyc(1'b1, 1'b0, '0, '0, 1'b1);
        d = '0;
        d[15:0] = 16'h7000;
        d[31:16] = 16'h9000;
        cyc(1'b0, 1'b1, d, 16'h20, 1'b1);
        for (int r = 1; r < ROW_A; r++) send(0, 16'h20 + r, 1'b1);
        d[15:0] = 16'h2000;
        d[31:16] = 16'hA000;
        cyc(1'b0, 1'b1, d, 16'h20, 1'b1);
        for (int r = 1; r < ROW_A; r++) send(0, 16'h20 + r, 1'b1);
        idle(6, 1'b1);
        chk("c2_nwrites", log_data.size(), 4);
        if (log_data.size() > 0) begin
            q = log_data[0];
            w16 = q[15:0];
            chk("c2_lane0", w16, 16'h7FFF);
            w16 = q[31:16];
            chk("c2_lane1", w16, 16'h8000);
        end

        // Case 3: backpressure during the final k-tile.
        clear_log();
        cyc(1'b1, 1'b0, '0, '0, 1'b1);
        for (int r = 0; r < ROW_A; r++) send(1, 16'h100 + r, 1'b1);
        for (int r = 0; r < ROW_A; r++) send(2, 16'h100 + r, 1'b0);
        idle(10, 1'b0);
        chk("c3_valid", valid, 1);
        chk("c3_ovf", overflow, 0);
        idle(8, 1'b1);
        chk("c3_nwrites", log_addr.size(), 4);
        for (int i = 0; i < log_addr.size(); i++) chk("c3_order", log_addr[i], 16'h100 + i);

        // Case 5a: tile_start coincident with deload mid-tile.
        clear_log();
        cyc(1'b1, 1'b0, '0, '0, 1'b1);
        send(1, 0, 1'b1);
        send(1, 1, 1'b1);
        cyc(1'b1, 1'b1, splat(9), 16'h200, 1'b1);
        for (int r = 1; r < ROW_A; r++) send(9, 16'h200 + r, 1'b1);
        for (int r = 0; r < ROW_A; r++) send(3, 16'h200 + r, 1'b1);
        idle(6, 1'b1);
        chk("c5_nwrites", log_data.size(), 4);
        for (int i = 0; i < log_data.size(); i++) chk("c5_data", log_data[i], splat(12));
        chk("c5_done", done_cnt, 1);

        // Case 5b: push and pop while full.
        clear_log();
        for (int r = 0; r < ROW_A; r++) send(1, 16'h300 + r, 1'b0);
        for (int r = 0; r < ROW_A; r++) send(2, 16'h300 + r, 1'b0);
        for (int r = 0; r < ROW_A; r++) send(4, 16'h400 + r, 1'b0);
        for (int r = 0; r < ROW_A; r++) send(4, 16'h400 + r, 1'b1);
        idle(8, 1'b1);
        chk("c5b_ovf", overflow, 0);
        chk("c5b_nwrites", log_data.size(), 8);
        for (int i = 4; i < log_data.size(); i++) chk("c5b_data", log_data[i], splat(8));

        // Case 4: overflow with ready held low.
        clear_log();
        for (int r = 0; r < ROW_A; r++) send(1, 16'h500 + r, 1'b0);
        for (int r = 0; r < ROW_A; r++) send(1, 16'h500 + r, 1'b0);
        for (int r = 0; r < ROW_A; r++) send(6, 16'h600 + r, 1'b0);
        for (int r = 0; r < ROW_A; r++) send(6, 16'h600 + r, 1'b0);
        chk("c4_ovf", overflow, 1);
        idle(8, 1'b1);
        chk("c4_nwrites", log_addr.size(), 4);
        for (int i = 0; i < log_addr.size(); i++) chk("c4_addr", log_addr[i], 16'h500 + i);
        chk("c4_ovf_sticky", overflow, 1);

        // Case 6: asynchronous reset mid-drain.
        clear_log();
        for (int r = 0; r < ROW_A; r++) send(2, r, 1'b0);
        for (int r = 0; r < ROW_A; r++) send(2, r, 1'b0);
        idle(1, 1'b1);
        chk("c6_pre_valid", valid, 1);
        reset_n = 1'b0;
        #1;
        chk("c6_async_valid", valid, 0);
        model_reset();
        tile_start = 1'b0;
        deload = 1'b0;
        ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        chk("c6_busy", busy, 0);
        chk("c6_ovf", overflow, 0);
        clear_log();
        for (int r = 0; r < ROW_A; r++) send(10, 16'h700 + r, 1'b1);
        for (int r = 0; r < ROW_A; r++) send(-3, 16'h700 + r, 1'b1);
        idle(6, 1'b1);
        chk("c6_nwrites", log_data.size(), 4);
        for (int i = 0; i < log_data.size(); i++) chk("c6_data", log_data[i], splat(7));
        chk("c6_done", done_cnt, 1);

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            for (int l = 0; l < ROW_A; l++) begin
                case ($urandom_range(0, 3))
                    0: d[OUT_WIDTH*l +: OUT_WIDTH] = SAT_MAX - OUT_WIDTH'($urandom_range(0, 255));
                    1: d[OUT_WIDTH*l +: OUT_WIDTH] = SAT_MIN + OUT_WIDTH'($urandom_range(0, 255));
                    default: d[OUT_WIDTH*l +: OUT_WIDTH] = OUT_WIDTH'($urandom);
                endcase
            end
            cyc(($urandom_range(0, 39) == 0), ($urandom_range(0, 1) == 1), d,
                ADDR_WIDTH'($urandom), ($urandom_range(0, 9) < 6));
        end
        idle(12, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/vpu_result_wb.md
Name: vpu_result_wb

Overview:
- Result writeback stage directly downstream of the VPU matmul datapath.
- Captures each ROW_A-lane result vector presented on `out` while `deload_out` is high, together with `addr_res`.
- Accumulates partial tiles across K_TILES successive k-tiles with signed saturating adds. Fully reduced rows are queued in a small FIFO.
- Drains the FIFO to result memory over a valid/ready write port, and reports completion and overflow to the controller.

Parameters:
OUT_WIDTH, 16, width of one signed result lane
ROW_A, 4, lanes per result vector and rows per tile
ADDR_WIDTH, 16, result memory address width
K_TILES, 2, number of k-tiles summed per output tile (>=1)
FIFO_DEPTH, 4, writeback FIFO entries (power of 2, >=2)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
deload_out  in  1  result row valid this cycle (no backpressure to source)
out  in  OUT_WIDTH*ROW_A  result row; lane n = out[OUT_WIDTH*n +: OUT_WIDTH], signed
addr_res  in  ADDR_WIDTH  result memory address of this row
tile_start  in  1  pulse: clear accumulator and counters before a new output tile
mem_wr_valid  out  1  write request valid
mem_wr_ready  in  1  memory accepts write when valid&&ready
mem_wr_addr  out  ADDR_WIDTH  write address
mem_wr_data  out  OUT_WIDTH*ROW_A  write data
tile_done  out  1  one-cycle pulse when last row of a tile has been written to memory
overflow  out  1  sticky: reduced row dropped because FIFO full
busy  out  1  accumulation in progress or FIFO non-empty

Behaviour:
- Reset (reset=0, asynchronous): row_cnt=0, k_cnt=0, accumulator bank zero, FIFO empty. Outputs mem_wr_valid=0, mem_wr_addr=0, mem_wr_data=0, tile_done=0, overflow=0, busy=0.
- Accumulator bank: ROW_A rows x ROW_A lanes x OUT_WIDTH. row_cnt (0..ROW_A-1) selects the row; k_cnt (0..K_TILES-1) counts k-tiles.
- Capture on a deload_out cycle:
  - If k_cnt==0: acc[row_cnt] <= out.
  - Otherwise: acc[row_cnt] <= sat(acc[row_cnt] + out), per lane, with signed saturation to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - row_cnt then increments. On wrap from ROW_A-1 to 0, k_cnt increments; on wrap from K_TILES-1 to 0, the tile is complete.
- Push on the final k-tile: when k_cnt==K_TILES-1, the saturated sum (not the stale acc) and addr_res are pushed into the FIFO in the same cycle. Accumulator-to-FIFO latency is 1 cycle.
- K_TILES==1: out passes straight to the FIFO, with no add.
- FIFO full at push: the row is dropped, overflow is set and stays set until reset, and counters still advance. A push and a pop in the same cycle are allowed when full: the pop frees a slot first, so nothing is dropped.
- Drain: mem_wr_valid = FIFO non-empty, with addr/data taken from the head entry. The head pops on valid&&ready.
  - mem_wr_valid, once asserted, stays high with stable addr/data until accepted.
  - When empty, mem_wr_addr and mem_wr_data hold their last values.
- tile_done pulses the cycle after the write of the final row of the final k-tile is accepted. A per-entry "last" tag travels through the FIFO to identify it.
- tile_start: clears row_cnt, k_cnt and acc next cycle. It does not flush the FIFO or clear overflow.
  - If deload_out coincides with tile_start, that row is treated as row 0 of k-tile 0 of the new tile.
- busy = (row_cnt!=0 || k_cnt!=0 || FIFO non-empty).
- Reset mid-operation: all state is discarded immediately, and any in-flight write is abandoned (valid drops asynchronously).

Decomposition:
- Shared config header: OUT_WIDTH, ROW_A, ADDR_WIDTH, K_TILES, FIFO_DEPTH, plus a macro for the saturation bounds.
- Sub-module vpu_wb_fifo: a parameterised synchronous FIFO with entries {last, addr, data}, outputs full/empty, and simultaneous push/pop when full.
- The saturating adder stays inline as a generate loop over the lanes.

Test Plan:
- Case 1, K_TILES=2, ROW_A=4, mem_wr_ready=1. Four rows of all lanes = 5 at addr 0..3, then four rows of all lanes = 7 at addr 0..3. Expected: four writes of lanes = 12 at addr 0,1,2,3; tile_done pulses once after the addr 3 write; busy then returns to 0.
- Case 2, saturation. Lane 0 = 0x7000 then 0x2000 → lane 0 written as 0x7FFF. Lane 1 = 0x9000 then 0xA000 → lane 1 written as 0x8000.
- Case 3, backpressure. Hold mem_wr_ready=0 for 10 cycles during the final k-tile → mem_wr_valid stays high, addr/data stay stable, 4 entries queue, and overflow stays 0. Releasing ready drains all 4 in order.
- Case 4, overflow. FIFO_DEPTH=2, ready=0, final-tile rows 0..3 → rows 2 and 3 are dropped and overflow=1. After ready=1 only addr 0 and 1 are written, and overflow stays 1.
- Case 5, simultaneous events.
  - tile_start coincident with deload_out (lanes = 9) mid-tile → new tile begins; final writes reflect 9 + the second-tile value.
  - Push and pop while full → no drop.
- Case 6, async reset asserted mid-drain with valid high → mem_wr_valid=0 immediately. After release, busy=0 and overflow=0, and a fresh tile completes correctly.
